// File: rtl/bit_packer_pkg.sv
// bit_packer_pkg: shared widths, fill type, FSM states and code-length saturation
package bit_packer_pkg;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 6;
    localparam int ACC_W  = 2 * DATA_W;
    typedef logic [LEN_W-1:0] fill_t;
    typedef enum logic [1:0] {RUN, DRAIN, LASTWAIT} state_t;
    localparam fill_t WORD_BITS = fill_t'(DATA_W);
    // lengths above one word are clamped to a full word
    function automatic fill_t sat_len(input fill_t len);
        return (len > WORD_BITS) ? WORD_BITS : len;
    endfunction
endpackage

// File: rtl/bit_packer_if.sv
// bit_packer_if: code input, flush control and packed-word output stream
interface bit_packer_if;
    import bit_packer_pkg::*;
    logic [DATA_W-1:0] in_data;
    fill_t             in_len;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic              flush_done;
    logic [DATA_W-1:0] out_data;
    fill_t             out_bits;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    fill_t             fill_level;
    modport master (
        output in_data, in_len, in_valid, flush, out_ready,
        input  in_ready, flush_done, out_data, out_bits, out_last, out_valid, fill_level
    );
    modport slave (
        input  in_data, in_len, in_valid, flush, out_ready,
        output in_ready, flush_done, out_data, out_bits, out_last, out_valid, fill_level
    );
endinterface

// File: rtl/bit_packer_code_aligner.sv
// code_aligner: masks a code to its saturated length and shifts it to its accumulator slot
module code_aligner
    import bit_packer_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    input  fill_t             len_i,
    input  fill_t             pos_i,
    output logic [ACC_W-1:0]  aligned_o
);
    logic [DATA_W-1:0] mask;
    // a full-word shift yields zero, so a 32-bit length gives an all-ones mask
    assign mask      = ~({DATA_W{1'b1}} << sat_len(len_i));
    assign aligned_o = {{(ACC_W-DATA_W){1'b0}}, data_i & mask} << pos_i;
endmodule

// File: rtl/bit_packer.sv
// bit_packer: appends variable-length codes LSB-first and emits fixed 32-bit words, with flush
module bit_packer
    import bit_packer_pkg::*;
(
    input logic         clk,
    input logic         rst,
    bit_packer_if.slave bus
);
    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d, aligned;
    fill_t             fill_q, fill_d, pos, len_sat;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    fill_t             out_bits_q, out_bits_d;
    logic              out_last_q, out_last_d, out_valid_q, out_valid_d;
    logic              free, emit, last_load, in_ready, accept;

    assign free      = !out_valid_q || bus.out_ready;
    assign emit      = (fill_q >= WORD_BITS) && free;
    assign last_load = (state_q == DRAIN) && (fill_q < WORD_BITS) && free;
    assign in_ready  = !rst && (state_q == RUN) && !bus.flush && ((fill_q < WORD_BITS) || emit);
    assign accept    = bus.in_valid && in_ready;
    assign pos       = emit ? fill_q - WORD_BITS : fill_q;
    assign len_sat   = sat_len(bus.in_len);

    code_aligner u_align (
        .data_i    (bus.in_data),
        .len_i     (bus.in_len),
        .pos_i     (pos),
        .aligned_o (aligned)
    );

    // next state: emit full words, insert accepted code, load the flush tail, step the FSM
    always_comb begin
        state_d     = state_q;
        acc_d       = emit ? acc_q >> DATA_W : acc_q;
        fill_d      = pos;
        out_data_d  = out_data_q;
        out_bits_d  = out_bits_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            acc_d  = acc_d | aligned;
            fill_d = pos + len_sat;
        end
        if (emit) begin
            out_data_d  = acc_q[DATA_W-1:0];
            out_bits_d  = WORD_BITS;
            out_last_d  = 1'b0;
            out_valid_d = 1'b1;
        end else if (last_load) begin
            out_data_d  = acc_q[DATA_W-1:0];
            out_bits_d  = fill_q;
            out_last_d  = 1'b1;
            out_valid_d = 1'b1;
            acc_d       = '0;
            fill_d      = '0;
        end else if (free) begin
            out_valid_d = 1'b0;
        end
        state_d = (state_q == RUN && bus.flush && !accept)                ? DRAIN    :
                  last_load                                               ? LASTWAIT :
                  (state_q == LASTWAIT && out_valid_q && bus.out_ready)   ? RUN      : state_q;
    end

    // state register; reset discards all buffered bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            acc_q       <= '0;
            fill_q      <= '0;
            out_data_q  <= '0;
            out_bits_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            out_data_q  <= out_data_d;
            out_bits_q  <= out_bits_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.flush_done = (state_q == LASTWAIT) && out_valid_q && bus.out_ready;
    assign bus.out_data   = out_data_q;
    assign bus.out_bits   = out_bits_q;
    assign bus.out_last   = out_last_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.fill_level = fill_q;
endmodule

// File: tb/tb_bit_packer.sv
// tb_bit_packer: directed and random stimulus checked against a bit-queue reference model
module tb_bit_packer;
    import bit_packer_pkg::*;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        fill_t             b;
        logic              l;
    } word_t;

    logic clk = 1'b0;
    logic rst;
    bit_packer_if bus();

    bit_packer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_fail = 0;
    int    n_out = 0;
    int    fd_cnt = 0;
    bit    bq[$];
    word_t expq[$];
    word_t last_w;
    logic  accepted;
    logic  flushing;
    int    o0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_push(input logic [DATA_W-1:0] data, input fill_t len);
        int    n;
        word_t w;
        n = (int'(len) > DATA_W) ? DATA_W : int'(len);
        for (int i = 0; i < n; i++) bq.push_back(data[i]);
        while (bq.size() >= DATA_W) begin
            w = '0;
            for (int i = 0; i < DATA_W; i++) w.d[i] = bq.pop_front();
            w.b = fill_t'(DATA_W);
            expq.push_back(w);
        end
    endtask

    task automatic model_flush();
        int    nb;
        word_t w;
        w  = '0;
        nb = bq.size();
        for (int i = 0; i < nb; i++) w.d[i] = bq.pop_front();
        w.b = fill_t'(nb);
        w.l = 1'b1;
        expq.push_back(w);
    endtask

    // one clock: observe handshakes just after the drive point, update the model, advance
    task automatic tick();
        word_t w;
        logic  fd_exp;
        #1;
        accepted = bus.in_valid && bus.in_ready;
        fd_exp   = 1'b0;
        if (bus.out_valid && bus.out_ready) begin
            n_out++;
            last_w = {bus.out_data, bus.out_bits, bus.out_last};
            chk("word_expected", expq.size() != 0, 1);
            if (expq.size() != 0) begin
                w = expq.pop_front();
                chk("out_data", bus.out_data, w.d);
                chk("out_bits", bus.out_bits, w.b);
                chk("out_last", bus.out_last, w.l);
                fd_exp = w.l;
            end
        end
        chk("flush_done", bus.flush_done, fd_exp);
        if (bus.flush_done === 1'b1) fd_cnt++;
        if (accepted) model_push(bus.in_data, bus.in_len);
        if (bus.flush && !flushing) begin
            flushing = 1'b1;
            model_flush();
        end else if (fd_exp) begin
            flushing = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input fill_t l);
        bus.in_data  = d;
        bus.in_len   = l;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (accepted) break;
        end
        chk("send_accepted", accepted, 1);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_flush();
        int c0;
        c0            = fd_cnt;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        tick();
        bus.flush = 1'b0;
        for (int k = 0; k < 20 && fd_cnt == c0; k++) tick();
        chk("flush_done_seen", fd_cnt - c0, 1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_data   = '0;
        bus.in_len    = '0;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        flushing      = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_fill", bus.fill_level, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_bits", bus.out_bits, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_flush_done", bus.flush_done, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rdy_after_rst", bus.in_ready, 1);
        @(negedge clk);

        send(32'h11, 6'd8);
        send(32'h22, 6'd8);
        send(32'h33, 6'd8);
        send(32'h44, 6'd8);
        bus.in_valid = 1'b0;
        #1;
        chk("lat_pre_valid", bus.out_valid, 0);
        tick();
        #1;
        chk("lat_valid", bus.out_valid, 1);
        chk("lat_data", bus.out_data, 32'h44332211);
        chk("lat_bits", bus.out_bits, 32);
        tick();
        chk("four_drained", expq.size(), 0);

        send(32'h7, 6'd3);
        send(32'hFFFF_FFFF, 6'd32);
        idle(1);
        chk("straddle_fill", bus.fill_level, 3);
        idle(1);
        chk("straddle_word", last_w.d, 32'hFFFF_FFFF);

        o0 = n_out;
        for (int i = 0; i < 8; i++) begin
            bus.in_data  = 32'hA5A5_A5A5;
            bus.in_len   = 6'd32;
            bus.in_valid = 1'b1;
            tick();
            chk("b2b_accept", accepted, 1);
        end
        idle(2);
        chk("b2b_words", n_out - o0, 8);

        bus.out_ready = 1'b0;
        send(32'hDEAD_BEEF, 6'd32);
        send(32'h1234_5678, 6'd32);
        bus.in_data = 32'hCAFE_F00D;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_no_accept", accepted, 0);
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_data_stable", bus.out_data, expq[0].d);
        end
        bus.out_ready = 1'b1;
        idle(3);
        chk("bp_drained", expq.size(), 0);

        do_flush();
        send(32'h5, 6'd3);
        send(32'h1, 6'd1);
        do_flush();
        chk("flush_word_data", last_w.d, 32'h0D);
        chk("flush_word_bits", last_w.b, 4);
        chk("flush_word_last", last_w.l, 1);
        #1;
        chk("flush_fill", bus.fill_level, 0);
        chk("flush_rdy", bus.in_ready, 1);
        @(negedge clk);
        do_flush();
        chk("empty_flush_bits", last_w.b, 0);
        chk("empty_flush_last", last_w.l, 1);
        chk("empty_flush_data", last_w.d, 0);

        repeat (3000) begin
            bus.flush     = (!flushing && $urandom_range(0, 39) == 0);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = $urandom;
            bus.in_len    = fill_t'($urandom_range(0, 40));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 200 && (expq.size() != 0 || flushing); k++) tick();
        tick();
        chk("rand_drained", expq.size(), 0);
        chk("rand_fill", bus.fill_level, bq.size());

        bus.in_data  = $urandom;
        bus.in_len   = 6'd20;
        bus.in_valid = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_fill", bus.fill_level, 0);
        chk("midrst_in_ready", bus.in_ready, 0);
        bq.delete();
        expq.delete();
        flushing = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_rdy_after", bus.in_ready, 1);
        chk("midrst_fill_after", bus.fill_level, 0);
        @(negedge clk);
        send(32'hBEEF, 6'd16);
        do_flush();
        chk("post_rst_flush_data", last_w.d, 32'hBEEF);
        chk("post_rst_flush_bits", last_w.b, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
